// File: rtl/sap_core.sv
// sap_core: minimal SAP-style accumulator CPU with on-chip program/data memory.
// Ports:
//   i_clk        - clock, all state changes on rising edge
//   i_rst        - synchronous active-high reset (memory contents preserved)
//   i_prog_we    - program-memory write strobe (honoured only in reset or HALT)
//   i_prog_addr  - program-memory write address
//   i_prog_data  - program-memory write data
//   o_out        - output register, loaded by OUT
//   o_out_valid  - one-cycle pulse when o_out is updated
//   o_halted     - high while in HALT
//   o_illegal    - sticky flag, set on an undefined opcode
module sap_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic              o_illegal
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned OP_W  = 4;

  // Opcode field must not overlap the operand field.
  if (DATA_W < ADDR_W + 4) begin : g_bad_width
    $error("sap_core: DATA_W must be at least ADDR_W+4");
  end

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_LDI = 4'h5;
  localparam logic [OP_W-1:0] OP_JMP = 4'h6;
  localparam logic [OP_W-1:0] OP_JC  = 4'h7;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_LOAD_IR = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a;
  logic [OP_W-1:0]   ir_op;
  logic [ADDR_W-1:0] ir_arg;
  logic              c_flag;
  logic              z_flag;

  // Control strobes from the output decoder.
  logic [ADDR_W-1:0] raddr_c;
  logic              ir_load_c;
  logic              jump_c;
  logic              ldi_c;
  logic              sta_c;
  logic              out_c;
  logic              illegal_c;
  logic              mem_op_c;
  logic              prog_ok_c;
  logic [DATA_W:0]   alu_c;

  assign o_halted = (state == S_HALT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   next_state = S_LOAD_IR;
      S_LOAD_IR: next_state = S_EXEC;
      S_EXEC: begin
        case (ir_op)
          OP_LDA, OP_ADD, OP_SUB: next_state = S_MEM;
          OP_HLT:                 next_state = S_HALT;
          default:                next_state = S_FETCH;
        endcase
      end
      S_MEM:   next_state = S_FETCH;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Output/control decode per state.
  always_comb begin
    raddr_c   = pc;
    ir_load_c = 1'b0;
    jump_c    = 1'b0;
    ldi_c     = 1'b0;
    sta_c     = 1'b0;
    out_c     = 1'b0;
    illegal_c = 1'b0;
    mem_op_c  = 1'b0;
    case (state)
      S_FETCH:   raddr_c = pc;
      S_LOAD_IR: ir_load_c = 1'b1;
      S_EXEC: begin
        raddr_c = ir_arg;
        case (ir_op)
          OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_HLT: ;
          OP_LDI: ldi_c  = 1'b1;
          OP_JMP: jump_c = 1'b1;
          OP_JC:  jump_c = c_flag;
          OP_JZ:  jump_c = z_flag;
          OP_STA: sta_c  = 1'b1;
          OP_OUT: out_c  = 1'b1;
          default: illegal_c = 1'b1;
        endcase
      end
      S_MEM:   mem_op_c = 1'b1;
      default: ;
    endcase
  end

  // SUB is A + ~M + 1 so the carry out means "no borrow".
  always_comb begin
    if (ir_op == OP_SUB)
      alu_c = (DATA_W+1)'({1'b0, a}) + (DATA_W+1)'({1'b0, ~rdata}) + (DATA_W+1)'(1);
    else
      alu_c = (DATA_W+1)'({1'b0, a}) + (DATA_W+1)'({1'b0, rdata});
  end

  assign prog_ok_c = i_prog_we && (i_rst || (state == S_HALT));

  // Memory: registered read, external program port or STA write.
  always_ff @(posedge i_clk) begin
    rdata <= mem[raddr_c];
    if (prog_ok_c)
      mem[i_prog_addr] <= i_prog_data;
    else if (sta_c && !i_rst)
      mem[ir_arg] <= a;
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= '0;
      a           <= '0;
      ir_op       <= '0;
      ir_arg      <= '0;
      c_flag      <= 1'b0;
      z_flag      <= 1'b0;
      o_out       <= '0;
      o_out_valid <= 1'b0;
      o_illegal   <= 1'b0;
    end else begin
      o_out_valid <= out_c;
      if (ir_load_c) begin
        ir_op  <= rdata[DATA_W-1 -: OP_W];
        ir_arg <= rdata[ADDR_W-1:0];
        pc     <= pc + ADDR_W'(1);
      end
      if (jump_c)    pc        <= ir_arg;
      if (ldi_c)     a         <= DATA_W'(ir_arg);
      if (out_c)     o_out     <= a;
      if (illegal_c) o_illegal <= 1'b1;
      if (mem_op_c) begin
        if (ir_op == OP_LDA) begin
          a <= rdata;
        end else begin
          a      <= alu_c[DATA_W-1:0];
          c_flag <= alu_c[DATA_W];
          z_flag <= (alu_c[DATA_W-1:0] == '0);
        end
      end
    end
  end

endmodule

// File: doc/sap_core.md
SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, meaning accumulator, memory word and output width.
REQ-002 The block SHALL expose parameter ADDR_W, default 4, meaning PC and operand width; memory depth is 2^ADDR_W words.
REQ-003 The block SHALL reject (elaboration-time error) DATA_W < ADDR_W+4.
REQ-004 The block SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port i_prog_we  input  1  program-memory write strobe.
REQ-007 The block SHALL have port i_prog_addr  input  ADDR_W  program-memory write address.
REQ-008 The block SHALL have port i_prog_data  input  DATA_W  program-memory write data.
REQ-009 The block SHALL have port o_out  output  DATA_W  output register.
REQ-010 The block SHALL have port o_out_valid  output  1  one-cycle pulse when o_out is updated.
REQ-011 The block SHALL have port o_halted  output  1  high while in HALT.
REQ-012 The block SHALL have port o_illegal  output  1  sticky; set on an undefined opcode.

Function
REQ-013 Instruction format SHALL be opcode = word[DATA_W-1:DATA_W-4] and operand = word[ADDR_W-1:0]; other bits are ignored.
REQ-014 Memory SHALL be 2^ADDR_W x DATA_W with a registered read: the address is presented in cycle n and the data is usable in cycle n+1.
REQ-015 The FSM SHALL have states FETCH, LOAD_IR, EXEC, MEM and HALT.
REQ-016 In FETCH the block SHALL drive the read address to PC and go to LOAD_IR.
REQ-017 In LOAD_IR the block SHALL do IR <= rdata and PC <= PC+1 (mod 2^ADDR_W), then go to EXEC.
REQ-018 EXEC SHALL perform these opcodes and then go to FETCH: 0 NOP; 5 LDI (A <= zero-extended operand); 6 JMP (PC <= operand); 7 JC (PC <= operand if C=1); 8 JZ (PC <= operand if Z=1); 4 STA (mem[operand] <= A); E OUT (o_out <= A, o_out_valid=1 on the next cycle).
REQ-019 For opcodes 1 LDA, 2 ADD and 3 SUB, EXEC SHALL drive the read address to operand and go to MEM.
REQ-020 MEM SHALL do LDA: A <= M; ADD: {C,A} <= A+M; SUB: {C,A} <= A+~M+1 (C=1 means no borrow); then go to FETCH.
REQ-021 Z SHALL be updated as (new A == 0) by ADD and SUB only; C SHALL be updated by ADD and SUB only; LDA and LDI SHALL leave the flags unchanged.
REQ-022 Opcode F HLT SHALL go from EXEC to HALT.
REQ-023 HALT SHALL be left only by reset; PC, A, flags and o_out SHALL be frozen in HALT.
REQ-024 An undefined opcode (9-D) SHALL set o_illegal, execute as NOP and continue.
REQ-025 Instruction latency SHALL be 3 cycles for NOP/LDI/JMP/JC/JZ/STA/OUT/HLT and 4 cycles for LDA/ADD/SUB.
REQ-026 Arithmetic SHALL be modulo 2^DATA_W; PC SHALL wrap from 2^ADDR_W-1 to 0.
REQ-027 A program write SHALL be accepted only when i_rst=1 or o_halted=1, and SHALL be ignored otherwise.
REQ-028 A jump to the instruction's own address SHALL be legal and SHALL loop indefinitely.

Reset
REQ-029 i_rst=1 at a clock edge SHALL set PC=0, A=0, IR=0, C=0, Z=0, o_out=0, o_out_valid=0, o_halted=0, o_illegal=0 and state=FETCH, from any state including mid-instruction and HALT.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 After i_rst deasserts, the first FETCH SHALL occur on the next edge.

Verification
REQ-032 Load under reset LDI 7; OUT; HLT at 0-2 -> o_out=0x07 and o_out_valid pulses once at cycle 6 after reset release; o_halted=1 at cycle 9.
REQ-033 Load LDA 14; ADD 15; OUT; HLT with mem[14]=0xF0 and mem[15]=0x20 -> o_out=0x10, C=1, Z=0; total 4+4+3+3 cycles.
REQ-034 Run SUB equal values followed by JZ to an OUT -> Z=1, C=1, jump taken; the same program with unequal values falls through.
REQ-035 Write a program word while running -> the write is ignored and memory is unchanged; the same write while halted -> the word is stored.
REQ-036 Assert reset during MEM of an ADD -> A, C and Z stay 0, and execution restarts at PC=0.
REQ-037 Run opcode 0xA, then JMP to address 15 holding OUT, then wrap -> o_illegal=1 is sticky, and after address 15 the PC wraps to 0.
